config_readback_capture: RTL and testbench

//  Downstream companion of the config-register shift interface. Watches the ConfigClk the FPGA drives to the chip
//  and the chip's ConfigOut return line. Deserialises the shifted-out register image into a word buffer that AXI

---
 rtl/config_reg_pkg.sv | 19 +
 rtl/cfg_sync_edge.sv | 32 +++
 rtl/config_readback_capture.sv | 162 ++++++++++++++++
 tb/tb_config_readback_capture.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/config_reg_pkg.sv
// Shared types and constants for the configuration readback capture block.
package config_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_FLUSH,
        ST_DONE
    } cfg_state_e;

    localparam int          CFG_WORD_W = 32;
    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

    function automatic int nwords(input int w);
        return (w + CFG_WORD_W - 1) / CFG_WORD_W;
    endfunction

endpackage

// File: rtl/cfg_sync_edge.sv
// Synchronises ConfigClk/ConfigOut into ACLK and flags ConfigClk falling edges.
module cfg_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_cfg_clk,
    input  logic i_cfg_data,
    output logic o_fedge,
    output logic o_data_s
);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_sync <= '0;
            r_dat_sync <= '0;
            r_clk_d    <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_cfg_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_cfg_data};
            r_clk_d    <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign o_fedge  = r_clk_d & ~r_clk_sync[SYNC_STAGES-1];
    assign o_data_s = r_dat_sync[SYNC_STAGES-1];

endmodule

// File: rtl/config_readback_capture.sv
// Deserialises the chip's ConfigOut stream into a readable word buffer.
// Optional running CRC-32 of captured bits when CFG_RB_CRC_EN is defined.
module config_readback_capture
    import config_reg_pkg::*;
#(
    parameter  int C_S_AXI_DATA_WIDTH = 32,
    parameter  int CONFIG_REG_WIDTH   = 5164,
    parameter  int SYNC_STAGES        = 2,
    localparam int NUM_WORDS = nwords(CONFIG_REG_WIDTH),
    localparam int WORD_AW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    localparam int CNT_W     = $clog2(CONFIG_REG_WIDTH + 1)
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    input  logic                          ConfigClk,
    input  logic                          ConfigOut,
    input  logic                          start,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic [CNT_W-1:0]              bit_cnt,
    output logic                          overflow,
    input  logic [WORD_AW-1:0]            rd_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] rd_data,
    output logic [31:0]                   crc
);

    localparam int                IDX_W    = $clog2(CFG_WORD_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(CONFIG_REG_WIDTH - 1);
    localparam bit                HAS_TAIL = (CONFIG_REG_WIDTH % CFG_WORD_W) != 0;

    cfg_state_e r_state, w_state_nxt;

    logic                          w_fedge;
    logic                          w_bit;
    logic                          w_cap;
    logic                          w_word_end;
    logic [IDX_W-1:0]              w_idx;
    logic [CNT_W-1:0]              r_bit_cnt;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_shreg;
    logic                          r_overflow;
    logic                          w_we;
    logic [WORD_AW-1:0]            w_waddr;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_wdata;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [NUM_WORDS];

    cfg_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk     (S_AXI_ACLK),
        .i_rst     (S_AXI_ARESET),
        .i_cfg_clk (ConfigClk),
        .i_cfg_data(ConfigOut),
        .o_fedge   (w_fedge),
        .o_data_s  (w_bit)
    );

    assign w_idx      = r_bit_cnt[IDX_W-1:0];
    assign w_word_end = (w_idx == IDX_W'(CFG_WORD_W - 1));
    assign w_cap      = (r_state == ST_CAPTURE) && w_fedge && !start && !abort;
    assign w_waddr    = WORD_AW'(r_bit_cnt >> IDX_W);

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) r_state <= ST_IDLE;
        else              r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_wdata     = {w_bit, r_shreg[C_S_AXI_DATA_WIDTH-2:0]};
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else if (start) begin
            w_state_nxt = ST_CAPTURE;
        end else begin
            unique case (r_state)
                ST_CAPTURE: begin
                    if (w_fedge) begin
                        w_we = w_word_end;
                        if (r_bit_cnt == LAST_BIT)
                            w_state_nxt = HAS_TAIL ? ST_FLUSH : ST_DONE;
                    end
                end
                ST_FLUSH: begin
                    w_we        = 1'b1;
                    w_wdata     = r_shreg;
                    w_state_nxt = ST_DONE;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // shreg is cleared after each full word so the tail word is already zero-padded
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
            r_overflow <= 1'b0;
        end else if (!abort) begin
            if (start) begin
                r_bit_cnt  <= '0;
                r_shreg    <= '0;
                r_overflow <= 1'b0;
            end else if (w_cap) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                if (w_word_end) r_shreg <= '0;
                else            r_shreg[w_idx] <= w_bit;
            end else if (r_state == ST_DONE && w_fedge) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    generate
        if (NUM_WORDS == (1 << WORD_AW)) begin : g_rd_full
            always_ff @(posedge S_AXI_ACLK) begin
                if (S_AXI_ARESET) rd_data <= '0;
                else              rd_data <= r_mem[rd_addr];
            end
        end else begin : g_rd_part
            always_ff @(posedge S_AXI_ACLK) begin
                if (S_AXI_ARESET)                     rd_data <= '0;
                else if (rd_addr < WORD_AW'(NUM_WORDS)) rd_data <= r_mem[rd_addr];
                else                                  rd_data <= '0;
            end
        end
    endgenerate

`ifdef CFG_RB_CRC_EN
    logic [31:0] r_crc;
    logic        w_fb;

    assign w_fb = r_crc[31] ^ w_bit;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_crc <= '0;
        end else if (!abort) begin
            if (start)
                r_crc <= CRC32_INIT;
            else if (w_cap)
                r_crc <= {r_crc[30:0], 1'b0} ^ (w_fb ? CRC32_POLY : 32'h0);
        end
    end

    assign crc = r_crc;
`else
    assign crc = '0;
`endif

    assign busy     = (r_state == ST_CAPTURE) || (r_state == ST_FLUSH);
    assign done     = (r_state == ST_DONE);
    assign bit_cnt  = r_bit_cnt;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_config_readback_capture.sv
// Directed bench for config_readback_capture (W=40, two sync stages).
module tb_config_readback_capture;

    localparam int W   = 40;
    localparam int AW  = 1;
    localparam int CW  = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_clk = 1'b0;
    logic          cfg_out = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, overflow;
    logic [CW-1:0] bit_cnt;
    logic [AW-1:0] rd_addr = '0;
    logic [31:0]   rd_data;
    logic [31:0]   crc;

    int n_vec = 0;
    int n_err = 0;

    config_readback_capture #(
        .C_S_AXI_DATA_WIDTH(32),
        .CONFIG_REG_WIDTH  (W),
        .SYNC_STAGES       (2)
    ) dut (
        .S_AXI_ACLK  (clk),
        .S_AXI_ARESET(rst),
        .ConfigClk   (cfg_clk),
        .ConfigOut   (cfg_out),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .bit_cnt     (bit_cnt),
        .overflow    (overflow),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .crc         (crc)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        cfg_clk = 1'b1;
        cfg_out = b;
        tick(10);
        cfg_clk = 1'b0;
        tick(10);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
    endtask

    task automatic read_word(input logic [AW-1:0] a, output logic [31:0] d);
        rd_addr = a;
        tick(1);
        d = rd_data;
    endtask

    function automatic logic [31:0] crc_model(input int nbits, input logic b);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < nbits; i++) begin
            fb = c[31] ^ b;
            c  = c << 1;
            if (fb) c = c ^ 32'h04C11DB7;
        end
        return c;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", overflow); end
        n_vec++; if (bit_cnt !== 6'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", bit_cnt); end
        n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL rst_rd: got %h want 0", rd_data); end
        n_vec++; if (crc !== 32'h0) begin n_err++; $display("FAIL rst_crc: got %h want 0", crc); end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_capture();
        logic [31:0] w0;
        logic [7:0]  w1;
        logic [31:0] d;
        w0 = 32'hA5A5A5A5;
        w1 = 8'hC3;
        pulse_start();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL cap_busy_start: got %b want 1", busy); end
        for (int i = 0; i < 32; i++) shift_bit(w0[i]);
        for (int i = 0; i < 8; i++) shift_bit(w1[i]);
        tick(3);
        n_vec++; if (bit_cnt !== 6'd40) begin n_err++; $display("FAIL cap_cnt: got %0d want 40", bit_cnt); end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL cap_done: got %b want 1", done); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL cap_busy: got %b want 0", busy); end
        read_word(1'b0, d);
        n_vec++; if (d !== 32'hA5A5A5A5) begin n_err++; $display("FAIL cap_w0: got %h want a5a5a5a5", d); end
        read_word(1'b1, d);
        n_vec++; if (d !== 32'h000000C3) begin n_err++; $display("FAIL cap_w1: got %h want 000000c3", d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        shift_bit(1'b1);
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", overflow); end
        n_vec++; if (bit_cnt !== 6'd40) begin n_err++; $display("FAIL ovf_cnt: got %0d want 40", bit_cnt); end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL ovf_done: got %b want 1", done); end
        read_word(1'b0, d);
        n_vec++; if (d !== 32'hA5A5A5A5) begin n_err++; $display("FAIL ovf_w0: got %h want a5a5a5a5", d); end
        read_word(1'b1, d);
        n_vec++; if (d !== 32'h000000C3) begin n_err++; $display("FAIL ovf_w1: got %h want 000000c3", d); end
        pulse_start();
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b want 0", overflow); end
        n_vec++; if (bit_cnt !== 6'd0) begin n_err++; $display("FAIL ovf_cnt_clr: got %0d want 0", bit_cnt); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL ovf_done_clr: got %b want 0", done); end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        pulse_start();
        for (int i = 0; i < 20; i++) shift_bit(i[0]);
        pulse_abort();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abt_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL abt_done: got %b want 0", done); end
        n_vec++; if (bit_cnt !== 6'd20) begin n_err++; $display("FAIL abt_cnt: got %0d want 20", bit_cnt); end
        read_word(1'b0, d);
        n_vec++; if (d !== 32'hA5A5A5A5) begin n_err++; $display("FAIL abt_w0: got %h want a5a5a5a5", d); end
        shift_bit(1'b1);
        n_vec++; if (bit_cnt !== 6'd20) begin n_err++; $display("FAIL abt_idle_cnt: got %0d want 20", bit_cnt); end
    endtask

    task automatic test_start_abort();
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sa_busy: got %b want 0", busy); end
        pulse_start();
        for (int i = 0; i < 3; i++) shift_bit(1'b1);
        n_vec++; if (bit_cnt !== 6'd3) begin n_err++; $display("FAIL sa_cnt3: got %0d want 3", bit_cnt); end
        // falling edge reaches the FSM two ACLK edges after the pin, act on the third
        cfg_clk = 1'b1;
        cfg_out = 1'b1;
        tick(10);
        cfg_clk = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(8);
        n_vec++; if (bit_cnt !== 6'd0) begin n_err++; $display("FAIL sa_fedge_cnt: got %0d want 0", bit_cnt); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL sa_fedge_busy: got %b want 1", busy); end
        shift_bit(1'b0);
        n_vec++; if (bit_cnt !== 6'd1) begin n_err++; $display("FAIL sa_next_cnt: got %0d want 1", bit_cnt); end
        pulse_abort();
    endtask

    task automatic test_crc();
        logic [31:0] d;
        logic [31:0] exp_crc;
`ifdef CFG_RB_CRC_EN
        exp_crc = crc_model(40, 1'b1);
`else
        exp_crc = 32'h0;
`endif
        pulse_start();
        for (int i = 0; i < 40; i++) shift_bit(1'b1);
        tick(3);
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL crc_done: got %b want 1", done); end
        n_vec++; if (crc !== exp_crc) begin n_err++; $display("FAIL crc_val: got %h want %h", crc, exp_crc); end
        read_word(1'b0, d);
        n_vec++; if (d !== 32'hFFFFFFFF) begin n_err++; $display("FAIL crc_w0: got %h want ffffffff", d); end
        read_word(1'b1, d);
        n_vec++; if (d !== 32'h000000FF) begin n_err++; $display("FAIL crc_w1: got %h want 000000ff", d); end
        tick(7);
        n_vec++; if (crc !== exp_crc) begin n_err++; $display("FAIL crc_hold: got %h want %h", crc, exp_crc); end
    endtask

    initial begin
        #1;
        test_reset();
        test_capture();
        test_overflow();
        test_abort();
        test_start_abort();
        test_crc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
